guess_game_ctrl: RTL and testbench
==================================

GUESS_GAME_CTRL -- requirements
Module: guess_game_ctrl

Interface
REQ-001 Parameter MAX_GUESSES, default 10, number of guesses allowed per round (legal range 1..255).
REQ-002 Parameter W, default 8, width of secret and guess values.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  begin a new round; sampled each rising edge.
REQ-006 secret  input  W  target value, captured when a start is accepted.
REQ-007 guess_valid  input  1  guess offered this cycle.
REQ-008 guess  input  W  guessed value, qualified by guess_valid.
REQ-009 guess_ready  output  1  controller accepts a guess this cycle.
REQ-010 play  output  1  round in progress.
REQ-011 totalGuesses  output  8  number of guesses accepted in the current round.
REQ-012 too_high / too_low  output  1 each  hint for the last accepted non-matching guess.
REQ-013 win / lose  output  1 each  round ended by a correct guess / by exhausting the guesses.
REQ-014 gameOver  output  1  round has ended (win OR lose).

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, PLAY, WON, LOST.
REQ-016 All outputs SHALL be registered or decoded from registered state; no combinational input-to-output path except guess_ready = (state==PLAY).
REQ-017 In any state, start=1 at an edge SHALL capture secret, clear totalGuesses, clear hints/win/lose and enter PLAY.
REQ-018 A guess is accepted only on an edge where guess_valid=1, guess_ready=1 and start=0.
REQ-019 On acceptance totalGuesses SHALL increment by 1 (visible the next cycle).
REQ-020 On acceptance with guess==stored secret the FSM SHALL enter WON, and hints SHALL clear.
REQ-021 On acceptance with guess!=secret and new count >= MAX_GUESSES the FSM SHALL enter LOST, and hints SHALL be updated.
REQ-022 Otherwise, on acceptance the FSM SHALL stay in PLAY, with too_high=(guess>secret) and too_low=(guess<secret), unsigned compare.
REQ-023 A correct guess on the final allowed attempt SHALL give WON, not LOST.
REQ-024 start and guess_valid in the same PLAY cycle: start wins, the guess is discarded and not counted.
REQ-025 In IDLE, WON and LOST, guess_valid SHALL be ignored and totalGuesses held.
REQ-026 play=(state==PLAY); win=(state==WON); lose=(state==LOST); gameOver=win|lose.
REQ-027 Hints SHALL hold their value between accepted guesses.
REQ-028 The secret register SHALL change only on start.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, totalGuesses=0, secret=0 and all 1-bit outputs to 0, independent of clk.
REQ-030 Reset asserted mid-round SHALL abandon the round; after release the block waits in IDLE for start.

Structure
REQ-031 Package guess_pkg SHALL hold the state enum (IDLE, PLAY, WON, LOST) and the default MAX_GUESSES constant.
REQ-032 The counter SHALL be a sub-module guess_counter (8-bit, synchronous clear, increment enable, asynchronous active-low reset).
REQ-033 The top level SHALL contain the FSM, the secret register and the hint registers only.

Verification
REQ-034 Reset, start with secret=42, guesses 10,50,42 -> too_low, then too_high, then win=1, gameOver=1, totalGuesses=3.
REQ-035 Start with secret=7, ten guesses of 0 -> lose=1 and gameOver=1 the cycle after the 10th; totalGuesses=10; an 11th guess_valid leaves the count at 10.
REQ-036 Nine wrong guesses, then a 10th guess equal to secret -> win=1, lose=0.
REQ-037 start and guess_valid together in PLAY with count=4 -> count=0, secret reloaded, guess discarded.
REQ-038 reset pulled low mid-clock during PLAY with count=5 -> IDLE, all outputs 0 before the next edge; guess_valid ignored until start.

Source files
------------

// File: rtl/guess_pkg.sv
// Shared types and defaults for the number-guessing round controller.
package guess_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    WON  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam int unsigned MAX_GUESSES_DEFAULT = 10;

endpackage : guess_pkg

// File: rtl/guess_game_ctrl_if.sv
// Round-control and guess handshake bundle between a player and the controller.
interface guess_game_ctrl_if #(
  parameter int unsigned W = 8
);

  logic         start;
  logic [W-1:0] secret;
  logic         guess_valid;
  logic [W-1:0] guess;
  logic         guess_ready;
  logic         play;
  logic [7:0]   totalGuesses;
  logic         too_high;
  logic         too_low;
  logic         win;
  logic         lose;
  logic         gameOver;

  modport slave (
    input  start, secret, guess_valid, guess,
    output guess_ready, play, totalGuesses, too_high, too_low, win, lose, gameOver
  );

  modport master (
    output start, secret, guess_valid, guess,
    input  guess_ready, play, totalGuesses, too_high, too_low, win, lose, gameOver
  );

endinterface : guess_game_ctrl_if

// File: rtl/guess_counter.sv
// 8-bit guess counter: synchronous clear has priority over increment.
module guess_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_count
);

  logic [7:0] r_count;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_count = r_count;

endmodule : guess_counter

// File: rtl/guess_game_ctrl.sv
// Round FSM for a guessing game: holds the secret, grades guesses, declares win/lose.
module guess_game_ctrl
  import guess_pkg::*;
#(
  parameter int unsigned MAX_GUESSES = MAX_GUESSES_DEFAULT,
  parameter int unsigned W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  guess_game_ctrl_if.slave io
);

  state_t       r_state;
  logic [W-1:0] r_secret;
  logic         r_too_high;
  logic         r_too_low;

  logic [7:0]   w_count;
  logic [8:0]   w_next_count;
  logic         w_accept;
  logic         w_match;
  logic         w_last;

  // start pre-empts a same-cycle guess, so it is never counted.
  assign w_accept     = io.guess_valid && (r_state == PLAY) && !io.start;
  assign w_match      = (io.guess == r_secret);
  assign w_next_count = {1'b0, w_count} + 9'd1;
  assign w_last       = (w_next_count >= 9'(MAX_GUESSES));

  guess_counter u_counter (
    .clk     (clk),
    .rst_n   (reset),
    .i_clr   (io.start),
    .i_inc   (w_accept),
    .o_count (w_count)
  );

  // NOTE: the secret is a single register, not a memory array, so it takes the async reset too.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_secret   <= '0;
      r_too_high <= 1'b0;
      r_too_low  <= 1'b0;
    end else if (io.start) begin
      r_state    <= PLAY;
      r_secret   <= io.secret;
      r_too_high <= 1'b0;
      r_too_low  <= 1'b0;
    end else if (w_accept) begin
      if (w_match) begin
        r_state    <= WON;
        r_too_high <= 1'b0;
        r_too_low  <= 1'b0;
      end else begin
        if (w_last) begin
          r_state <= LOST;
        end
        r_too_high <= (io.guess > r_secret);
        r_too_low  <= (io.guess < r_secret);
      end
    end
  end

  assign io.guess_ready  = (r_state == PLAY);
  assign io.play         = (r_state == PLAY);
  assign io.win          = (r_state == WON);
  assign io.lose         = (r_state == LOST);
  assign io.gameOver     = (r_state == WON) || (r_state == LOST);
  assign io.too_high     = r_too_high;
  assign io.too_low      = r_too_low;
  assign io.totalGuesses = w_count;

endmodule : guess_game_ctrl

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl: directed rounds, expectations queued per cycle.
module tb_guess_game_ctrl;

  typedef enum logic [1:0] {E_IDLE, E_PLAY, E_WON, E_LOST} exp_state_t;

  typedef struct {
    string       name;
    logic [14:0] vec;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  guess_game_ctrl_if #(.W(8)) bus ();

  guess_game_ctrl #(
    .MAX_GUESSES (10),
    .W           (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Output vector layout: {ready, play, win, lose, over, too_high, too_low, count[7:0]}
  function automatic exp_t mk(string name, exp_state_t st, logic th, logic tl, int unsigned total);
    exp_t e;
    logic p, w, l;
    p      = (st == E_PLAY);
    w      = (st == E_WON);
    l      = (st == E_LOST);
    e.name = name;
    e.vec  = {p, p, w, l, w | l, th, tl, 8'(total)};
    return e;
  endfunction

  task automatic check(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rdy/play/win/lose/over/hi/lo=%b count=%0d, want %b count=%0d",
               name, act[14:8], act[7:0], exp[14:8], exp[7:0]);
    end
  endtask

  // Monitor: compare one queued expectation on each falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check(mon_e.name,
            {bus.guess_ready, bus.play, bus.win, bus.lose, bus.gameOver,
             bus.too_high, bus.too_low, bus.totalGuesses},
            mon_e.vec);
    end
  end

  task automatic step(string name, logic st, logic [7:0] sec, logic gv, logic [7:0] g,
                      exp_state_t es, logic th, logic tl, int unsigned total);
    @(negedge clk);
    bus.start       = st;
    bus.secret      = sec;
    bus.guess_valid = gv;
    bus.guess       = g;
    @(posedge clk);
    #1;
    sb.push_back(mk(name, es, th, tl, total));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  initial begin
    bus.start       = 1'b0;
    bus.secret      = 8'd0;
    bus.guess_valid = 1'b0;
    bus.guess       = 8'd0;

    step("reset", 1'b0, 8'd0, 1'b0, 8'd0, E_IDLE, 1'b0, 1'b0, 0);
    @(negedge clk);
    reset = 1'b1;

    // Secret 42; the secret input wanders afterwards and must be ignored.
    step("s1_start", 1'b1, 8'd42, 1'b0, 8'd0,  E_PLAY, 1'b0, 1'b0, 0);
    step("s1_g10",   1'b0, 8'd99, 1'b1, 8'd10, E_PLAY, 1'b0, 1'b1, 1);
    step("s1_g50",   1'b0, 8'd99, 1'b1, 8'd50, E_PLAY, 1'b1, 1'b0, 2);
    step("s1_g42",   1'b0, 8'd99, 1'b1, 8'd42, E_WON,  1'b0, 1'b0, 3);
    step("s1_won_ignore", 1'b0, 8'd99, 1'b1, 8'd42, E_WON, 1'b0, 1'b0, 3);

    // Exhaust all ten guesses.
    step("s2_start", 1'b1, 8'd7, 1'b0, 8'd0, E_PLAY, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 9; i++)
      step("s2_miss", 1'b0, 8'd7, 1'b1, 8'd0, E_PLAY, 1'b0, 1'b1, i);
    step("s2_g10_lose", 1'b0, 8'd7, 1'b1, 8'd0, E_LOST, 1'b0, 1'b1, 10);
    step("s2_g11_held", 1'b0, 8'd7, 1'b1, 8'd0, E_LOST, 1'b0, 1'b1, 10);

    // Correct guess on the final allowed attempt wins.
    step("s3_start", 1'b1, 8'd100, 1'b0, 8'd0, E_PLAY, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 9; i++)
      step("s3_miss", 1'b0, 8'd100, 1'b1, 8'd200, E_PLAY, 1'b1, 1'b0, i);
    step("s3_last_hit", 1'b0, 8'd100, 1'b1, 8'd100, E_WON, 1'b0, 1'b0, 10);

    // start beats a same-cycle guess; the new secret takes effect.
    step("s4_start", 1'b1, 8'd30, 1'b0, 8'd0, E_PLAY, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 4; i++)
      step("s4_miss", 1'b0, 8'd30, 1'b1, 8'd5, E_PLAY, 1'b0, 1'b1, i);
    step("s4_start_wins", 1'b1, 8'd60, 1'b1, 8'd60, E_PLAY, 1'b0, 1'b0, 0);
    step("s4_g30_old",    1'b0, 8'd0,  1'b1, 8'd30, E_PLAY, 1'b0, 1'b1, 1);
    step("s4_g60_new",    1'b0, 8'd0,  1'b1, 8'd60, E_WON,  1'b0, 1'b0, 2);

    // Asynchronous reset mid-round, between clock edges.
    step("s5_start", 1'b1, 8'd9, 1'b0, 8'd0, E_PLAY, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 5; i++)
      step("s5_miss", 1'b0, 8'd9, 1'b1, 8'd3, E_PLAY, 1'b0, 1'b1, i);
    step("s5_hint_hold", 1'b0, 8'd9, 1'b0, 8'd0, E_PLAY, 1'b0, 1'b1, 5);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    sb.push_back(mk("s5_async_rst", E_IDLE, 1'b0, 1'b0, 0));
    step("s5_rst_held", 1'b0, 8'd9, 1'b1, 8'd9, E_IDLE, 1'b0, 1'b0, 0);
    reset = 1'b1;
    step("s5_idle_ignore", 1'b0, 8'd9, 1'b1, 8'd9, E_IDLE, 1'b0, 1'b0, 0);
    step("s5_restart",     1'b1, 8'd9, 1'b0, 8'd0, E_PLAY, 1'b0, 1'b0, 0);
    step("s5_hit",         1'b0, 8'd9, 1'b1, 8'd9, E_WON,  1'b0, 1'b0, 1);

    for (int i = 0; i < 5 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked expectations, want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_guess_game_ctrl
